// File: rtl/wb_skid_stage.sv
// wb_skid_stage: MEM->WB pipeline stage with a two-entry skid buffer.
// Latency: a request accepted at edge N appears on out_* after edge N.
// Backpressure: in_ready is registered and drops only when the skid slot is full.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            memory-stage handshake
//   in_wd, in_wreg, in_wdata     incoming register-file write request
//   flush                        drop every held and incoming request
//   out_valid/out_ready          write-port handshake
//   out_wd, out_wreg, out_wdata  request presented to the write port (zero when empty)
//   wb_count                     completed output handshakes that wrote a register
module wb_skid_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter bit ZERO_FILTER = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_wd,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic [CNT_W-1:0]  wb_count
);

  typedef struct packed {
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // State is named by occupancy: number of valid slots.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  req_t             main_q, main_d;
  req_t             skid_q, skid_d;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic in_hs;
  logic out_hs;
  req_t in_req;

  assign in_hs  = in_valid && in_ready_q;
  assign out_hs = out_valid_q && out_ready;

  // Writes to register 0 keep their slot and handshake but never write.
  always_comb begin
    in_req       = '0;
    in_req.wd    = in_wd;
    in_req.wdata = in_wdata;
    in_req.wreg  = in_wreg && !(ZERO_FILTER && (in_wd == '0));
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_hs) begin
          state_d = ONE;
          main_d  = in_req;
        end
      end
      ONE: begin
        if (in_hs && out_hs) begin
          main_d = in_req;
        end else if (out_hs) begin
          state_d = EMPTY;
          main_d  = '0;       // empty main slot presents a NOP bubble
        end else if (in_hs) begin
          state_d = TWO;
          skid_d  = in_req;
        end
      end
      TWO: begin
        // in_ready is low here, so only the output side can move.
        if (out_hs) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
    // Flush overrides everything, including this cycle's accepted input.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      // Handshake flags are registered copies of the next occupancy, so
      // in_ready has no combinational path from out_ready.
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
    end
  end

  // Counts retired writes; the coincident handshake of a flush still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_hs && main_q.wreg) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_wd    = main_q.wd;
  assign out_wreg  = main_q.wreg;
  assign out_wdata = main_q.wdata;
  assign wb_count  = cnt_q;

endmodule

// File: tb/tb_wb_skid_stage.sv
// Self-checking bench for wb_skid_stage (CNT_W=4 so the counter wrap is reachable).
module tb_wb_skid_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_wd;
  logic              in_wreg;
  logic [DATA_W-1:0] in_wdata;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] out_wd;
  logic              out_wreg;
  logic [DATA_W-1:0] out_wdata;
  logic [CNT_W-1:0]  wb_count;

  wb_skid_stage #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W), .ZERO_FILTER(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
    .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a FIFO of at most two entries -------
  typedef struct {
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
  } ent_t;

  ent_t             mq[$];
  logic [CNT_W-1:0] mcnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mcnt = '0;
    end else begin
      bit acc, ret;
      ent_t e;
      acc = in_valid && (mq.size() < 2);
      ret = (mq.size() > 0) && out_ready;
      if (ret && mq[0].wreg) mcnt = mcnt + 1'b1;
      if (flush) begin
        mq.delete();
      end else begin
        if (ret) void'(mq.pop_front());
        if (acc) begin
          e.wd    = in_wd;
          e.wreg  = in_wreg && (in_wd != 0);
          e.wdata = in_wdata;
          mq.push_back(e);
        end
      end
    end
  end

  // Single compare process: every negedge, DUT outputs vs. model.
  always @(negedge clk) begin
    chk("m_out_valid", out_valid, mq.size() > 0);
    chk("m_in_ready",  in_ready,  mq.size() < 2);
    chk("m_out_wd",    out_wd,    (mq.size() > 0) ? mq[0].wd    : '0);
    chk("m_out_wreg",  out_wreg,  (mq.size() > 0) ? mq[0].wreg  : 1'b0);
    chk("m_out_wdata", out_wdata, (mq.size() > 0) ? mq[0].wdata : '0);
    chk("m_wb_count",  wb_count,  mcnt);
  end

  // Records output handshakes as seen on the DUT pins.
  int seen[$];
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) seen.push_back(int'(out_wd));
  end

  task automatic step(input bit iv, input int wd, input bit wr,
                      input logic [DATA_W-1:0] wdat, input bit fl, input bit ordy);
    in_valid  = iv;
    in_wd     = wd[REG_AW-1:0];
    in_wreg   = wr;
    in_wdata  = wdat;
    flush     = fl;
    out_ready = ordy;
    @(negedge clk);
  endtask

  int exp_bp[4] = '{1, 2, 3, 4};

  initial begin
    rst = 1'b0;
    in_valid = 0; in_wd = '0; in_wreg = 0; in_wdata = '0; flush = 0; out_ready = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_wb_count",  wb_count,  4'd0);
    rst = 1'b0;
    @(negedge clk);

    // Streaming: 8 back-to-back requests, one cycle latency, no bubbles.
    for (int i = 1; i <= 8; i++) begin
      step(1, i, 1, 32'h100 + i, 0, 1);
      chk("stream_wd",    out_wd,    i);
      chk("stream_wdata", out_wdata, 32'h100 + i);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("stream_count", wb_count, 4'd8);
    chk("stream_empty", out_valid, 1'b0);

    // Back-pressure: out_ready low for 3 cycles after wd=1 appears.
    seen.delete();
    step(1, 1, 1, 32'h201, 0, 1);
    step(1, 2, 1, 32'h202, 0, 0);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_head", out_wd, 5'd1);
    step(1, 3, 1, 32'h203, 0, 0);
    step(1, 3, 1, 32'h203, 0, 0);
    step(1, 3, 1, 32'h203, 0, 1);
    chk("bp_in_ready_back", in_ready, 1'b1);
    step(1, 3, 1, 32'h203, 0, 1);
    step(1, 4, 1, 32'h204, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("bp_n", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_order", (i < seen.size()) ? seen[i] : -1, exp_bp[i]);
    chk("bp_count", wb_count, 4'd12);

    // Zero-register write is carried as a NOP write.
    step(1, 0, 1, 32'hDEADBEEF, 0, 0);
    chk("zf_valid", out_valid, 1'b1);
    chk("zf_wreg",  out_wreg,  1'b0);
    chk("zf_wd",    out_wd,    5'd0);
    chk("zf_wdata", out_wdata, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 1);
    chk("zf_done",  out_valid, 1'b0);
    chk("zf_count", wb_count,  4'd12);

    // Flush in TWO with a coincident output handshake and input request.
    step(1, 5, 1, 32'h305, 0, 0);
    step(1, 6, 1, 32'h306, 0, 0);
    chk("fl_full", in_ready, 1'b0);
    step(1, 7, 1, 32'h307, 1, 1);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ready", in_ready,  1'b1);
    chk("fl_wd",    out_wd,    5'd0);
    chk("fl_count", wb_count,  4'd13);
    step(0, 0, 0, 0, 0, 1);
    chk("fl_no_ghost", out_valid, 1'b0);

    // Asynchronous reset mid-cycle with two entries held.
    step(1, 9, 1, 32'h409, 0, 0);
    step(1, 10, 1, 32'h40A, 0, 0);
    in_valid = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_out_wreg",  out_wreg,  1'b0);
    chk("ar_out_wd",    out_wd,    5'd0);
    chk("ar_out_wdata", out_wdata, 32'd0);
    chk("ar_in_ready",  in_ready,  1'b1);
    chk("ar_wb_count",  wb_count,  4'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Counter wrap: 17 writing handshakes on a 4-bit counter.
    for (int i = 0; i < 17; i++) step(1, (i % 31) + 1, 1, i, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_count", wb_count, 4'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 31), $urandom_range(0, 1),
           $urandom, $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
